// File: rtl/sysid_checker.sv
`default_nettype none
// ============================================================================
//  Module   : sysid_checker
//  Purpose  : Boot-time identity sequencer for an Avalon-MM system-ID slave.
//             After reset (and on each start pulse once a result is shown)
//             it reads word 0 (system ID) and word 1 (build timestamp),
//             compares them with build-time constants and publishes the
//             result. Bus timeouts are retried; responses belonging to an
//             abandoned read are discarded.
//  Ports    : clock, reset_n        - clock / asynchronous active-low reset
//             start                 - one-cycle re-check request (DONE only)
//             avm_*                 - Avalon-MM read master
//             busy, done, pass      - sequence status and overall result
//             id_ok, ts_ok          - per-field match
//             timeout_err           - retries exhausted
//             retry_count           - timeouts taken this sequence
//             id_value, ts_value    - captured words
//  Revision : 1.0  initial release
// ============================================================================
module sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1343036306,
    parameter int unsigned TIMEOUT_CYCLES     = 255,
    parameter int unsigned MAX_RETRIES        = 3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic        avm_readdatavalid,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout_err,
    output logic [3:0]  retry_count,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ID_REQ  = 3'd1,
        S_ID_WAIT = 3'd2,
        S_TS_REQ  = 3'd3,
        S_TS_WAIT = 3'd4,
        S_EVAL    = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    localparam logic [8:0] TO_LIMIT    = 9'(TIMEOUT_CYCLES);
    localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRIES);

    state_t      state_q;
    logic [7:0]  cnt_q;     // cycles spent on the current read
    logic        stale_q;   // a response from an abandoned read is still due

    logic        w_in_req;
    logic        w_in_wait;
    logic        w_capture;
    logic        w_cnt_hit;
    logic        w_timeout;
    logic        w_retry_ok;
    logic [7:0]  w_cnt_inc;

    assign w_in_req   = (state_q == S_ID_REQ)  || (state_q == S_TS_REQ);
    assign w_in_wait  = (state_q == S_ID_WAIT) || (state_q == S_TS_WAIT);
    // A strobe only counts as our data once any stale response has been eaten.
    assign w_capture  = w_in_wait && avm_readdatavalid && !stale_q;
    assign w_cnt_inc  = cnt_q + 8'd1;
    // 9-bit compare so the incremented count can never wrap past the limit.
    assign w_cnt_hit  = (({1'b0, cnt_q} + 9'd1) == TO_LIMIT);
    assign w_timeout  = (w_in_req || w_in_wait) && w_cnt_hit && !w_capture;
    assign w_retry_ok = (retry_count < RETRY_LIMIT);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            stale_q     <= 1'b0;
            avm_address <= 1'b0;
            avm_read    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout_err <= 1'b0;
            retry_count <= '0;
            id_value    <= '0;
            ts_value    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q     <= S_ID_REQ;
                    busy        <= 1'b1;
                    avm_read    <= 1'b1;
                    avm_address <= 1'b0;
                    cnt_q       <= '0;
                end
                S_ID_REQ, S_TS_REQ: begin
                    cnt_q <= w_cnt_inc;
                    if (!avm_waitrequest) begin
                        avm_read <= 1'b0;
                        state_q  <= (state_q == S_ID_REQ) ? S_ID_WAIT : S_TS_WAIT;
                    end
                end
                S_ID_WAIT, S_TS_WAIT: begin
                    cnt_q <= w_cnt_inc;
                    if (w_capture) begin
                        if (state_q == S_ID_WAIT) begin
                            id_value    <= avm_readdata;
                            state_q     <= S_TS_REQ;
                            avm_read    <= 1'b1;
                            avm_address <= 1'b1;
                            cnt_q       <= '0;
                        end else begin
                            ts_value <= avm_readdata;
                            state_q  <= S_EVAL;
                        end
                    end else if (avm_readdatavalid) begin
                        stale_q <= 1'b0;
                    end
                end
                S_EVAL: begin
                    id_ok   <= !timeout_err && (id_value == EXPECTED_ID);
                    ts_ok   <= !timeout_err && (ts_value == EXPECTED_TIMESTAMP);
                    pass    <= !timeout_err && (id_value == EXPECTED_ID)
                                            && (ts_value == EXPECTED_TIMESTAMP);
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    if (start) begin
                        done        <= 1'b0;
                        pass        <= 1'b0;
                        id_ok       <= 1'b0;
                        ts_ok       <= 1'b0;
                        timeout_err <= 1'b0;
                        retry_count <= '0;
                        busy        <= 1'b1;
                        avm_read    <= 1'b1;
                        avm_address <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= S_ID_REQ;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            // Timeout overrides whatever the state logic chose this edge.
            if (w_timeout) begin
                avm_address <= 1'b0;
                cnt_q       <= '0;
                // An accepted read whose data never arrived will answer later.
                if (w_in_wait || !avm_waitrequest) begin
                    stale_q <= 1'b1;
                end
                if (w_retry_ok) begin
                    retry_count <= retry_count + 4'd1;
                    avm_read    <= 1'b1;
                    state_q     <= S_ID_REQ;
                end else begin
                    timeout_err <= 1'b1;
                    avm_read    <= 1'b0;
                    state_q     <= S_EVAL;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sysid_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sysid_checker
//  Purpose  : Self-checking bench for sysid_checker. Instance 0 uses default
//             parameters; instance 1 uses TIMEOUT_CYCLES=8, MAX_RETRIES=2.
//             A behavioural Avalon slave per instance supplies configurable
//             wait states, latency, dropped reads and late stale responses.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sysid_checker;

    localparam logic [31:0] TS_GOOD = 32'd1343036306;

    logic        clock = 1'b0;
    logic        rst_n       [2];
    logic        start       [2];
    logic        avm_address [2];
    logic        avm_read    [2];
    logic        wr          [2];
    logic        rdv         [2];
    logic [31:0] rdata       [2];
    logic        busy        [2];
    logic        done        [2];
    logic        pass        [2];
    logic        id_ok       [2];
    logic        ts_ok       [2];
    logic        terr        [2];
    logic [3:0]  retry       [2];
    logic [31:0] id_value    [2];
    logic [31:0] ts_value    [2];

    // Slave configuration (written by the test process only)
    logic [31:0] cfg_id    [2];
    logic [31:0] cfg_ts    [2];
    int          cfg_ws    [2];
    int          cfg_lat   [2];
    int          cfg_drop  [2];
    bit          cfg_stuck [2];

    // Slave state (written by the slave process only)
    int          stall   [2];
    int          pend    [2];
    logic        paddr   [2];
    int          dropped [2];
    bit          arm     [2];

    int n_chk = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    sysid_checker u_dut0 (
        .clock(clock), .reset_n(rst_n[0]), .start(start[0]),
        .avm_address(avm_address[0]), .avm_read(avm_read[0]),
        .avm_waitrequest(wr[0]), .avm_readdatavalid(rdv[0]), .avm_readdata(rdata[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]), .id_ok(id_ok[0]), .ts_ok(ts_ok[0]),
        .timeout_err(terr[0]), .retry_count(retry[0]), .id_value(id_value[0]), .ts_value(ts_value[0])
    );

    sysid_checker #(.TIMEOUT_CYCLES(8), .MAX_RETRIES(2)) u_dut1 (
        .clock(clock), .reset_n(rst_n[1]), .start(start[1]),
        .avm_address(avm_address[1]), .avm_read(avm_read[1]),
        .avm_waitrequest(wr[1]), .avm_readdatavalid(rdv[1]), .avm_readdata(rdata[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]), .id_ok(id_ok[1]), .ts_ok(ts_ok[1]),
        .timeout_err(terr[1]), .retry_count(retry[1]), .id_value(id_value[1]), .ts_value(ts_value[1])
    );

    // Behavioural slave: inputs for the next rising edge are set on the falling edge.
    always @(negedge clock) begin
        for (int i = 0; i < 2; i++) begin
            rdv[i] = 1'b0;
            if (!rst_n[i]) begin
                wr[i] = 1'b0; pend[i] = 0; stall[i] = 0; dropped[i] = 0; arm[i] = 1'b0;
            end else begin
                if (pend[i] > 0) begin
                    pend[i] = pend[i] - 1;
                    if (pend[i] == 0) begin
                        if (dropped[i] < cfg_drop[i]) begin
                            dropped[i] = dropped[i] + 1;
                            arm[i] = 1'b1;   // the lost response shows up during the next read
                        end else begin
                            rdv[i] = 1'b1;
                            rdata[i] = paddr[i] ? cfg_ts[i] : cfg_id[i];
                        end
                    end else if (arm[i]) begin
                        rdv[i] = 1'b1;
                        rdata[i] = 32'hDEAD_BEEF;
                        arm[i] = 1'b0;
                    end
                end
                if (avm_read[i] && cfg_stuck[i]) begin
                    wr[i] = 1'b1;
                end else if (avm_read[i] && stall[i] < cfg_ws[i]) begin
                    wr[i] = 1'b1;
                    stall[i] = stall[i] + 1;
                end else begin
                    wr[i] = 1'b0;
                    if (avm_read[i]) begin
                        stall[i] = 0;
                        pend[i] = cfg_lat[i];
                        paddr[i] = avm_address[i];
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic edge_s();
        @(posedge clock);
        #1;
    endtask

    task automatic set_cfg(input int s, input logic [31:0] id, input logic [31:0] ts,
                           input int ws, input int lat, input int drop, input bit stuck);
        cfg_id[s] = id; cfg_ts[s] = ts; cfg_ws[s] = ws;
        cfg_lat[s] = lat; cfg_drop[s] = drop; cfg_stuck[s] = stuck;
    endtask

    // Reset held across two falling edges; the next rising edge is edge 1.
    task automatic reset_pulse(input int s);
        @(negedge clock);
        rst_n[s] = 1'b0;
        @(negedge clock);
        @(negedge clock);
        rst_n[s] = 1'b1;
    endtask

    // Returns the number of edges until done is seen (0 if the bound expires).
    task automatic wait_done(input int s, input bit chk_stable, output int n);
        logic p_rd, p_addr, p_wr;
        n = 0;
        for (int k = 1; k <= 2000; k++) begin
            p_rd = avm_read[s];
            p_addr = avm_address[s];
            @(posedge clock);
            p_wr = wr[s];
            #1;
            if (chk_stable && p_rd && p_wr) begin
                chk("stall_read_held", {31'd0, avm_read[s]}, 32'd1);
                chk("stall_addr_held", {31'd0, avm_address[s]}, {31'd0, p_addr});
            end
            if (done[s]) begin
                n = k;
                break;
            end
        end
    endtask

    typedef struct {
        int          sel;
        logic [31:0] id, ts;
        int          ws, lat, drop;
        bit          stuck;
        int          edges;
        bit          pass, id_ok, ts_ok, terr;
        logic [3:0]  retry;
        logic [31:0] idv, tsv;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int n;
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        start[0] = 1'b0; start[1] = 1'b0;
        set_cfg(0, 32'd0, TS_GOOD, 0, 1, 0, 1'b0);
        set_cfg(1, 32'd0, TS_GOOD, 0, 1, 0, 1'b0);

        //            sel id            ts            ws lat drop stuck edges pass id  ts  terr retry idv           tsv
        vecs[0] = '{0, 32'd0,        TS_GOOD,      0, 1,  0,  1'b0, 6,  1'b1,1'b1,1'b1,1'b0,4'd0,32'd0,        TS_GOOD};
        vecs[1] = '{0, 32'd0,        TS_GOOD+1,    0, 1,  0,  1'b0, 6,  1'b0,1'b1,1'b0,1'b0,4'd0,32'd0,        TS_GOOD+1};
        vecs[2] = '{0, 32'd5,        TS_GOOD,      5, 1,  0,  1'b0, 16, 1'b0,1'b0,1'b1,1'b0,4'd0,32'd5,        TS_GOOD};
        vecs[3] = '{0, 32'd0,        TS_GOOD,      2, 2,  0,  1'b0, 12, 1'b1,1'b1,1'b1,1'b0,4'd0,32'd0,        TS_GOOD};
        vecs[4] = '{0, 32'hFFFFFFFF, 32'd0,        0, 3,  0,  1'b0, 10, 1'b0,1'b0,1'b0,1'b0,4'd0,32'hFFFFFFFF, 32'd0};
        vecs[5] = '{1, 32'd0,        TS_GOOD,      0, 2,  1,  1'b0, 16, 1'b1,1'b1,1'b1,1'b0,4'd1,32'd0,        TS_GOOD};
        vecs[6] = '{1, 32'd0,        TS_GOOD,      0, 1,  0,  1'b1, 26, 1'b0,1'b0,1'b0,1'b1,4'd2,32'd0,        32'd0};

        // Reset state of both instances
        #1;
        rst_n[0] = 1'b0; rst_n[1] = 1'b0;
        #2;
        for (int s = 0; s < 2; s++) begin
            chk("reset_ctrl", {22'd0, avm_read[s], avm_address[s], busy[s], done[s], pass[s],
                               id_ok[s], ts_ok[s], terr[s], retry[s][1:0]}, 32'd0);
            chk("reset_retry", {28'd0, retry[s]}, 32'd0);
            chk("reset_id_value", id_value[s], 32'd0);
            chk("reset_ts_value", ts_value[s], 32'd0);
        end
        @(negedge clock);
        @(negedge clock);

        // Table-driven full sequences
        for (int v = 0; v < 7; v++) begin
            int s;
            s = vecs[v].sel;
            set_cfg(s, vecs[v].id, vecs[v].ts, vecs[v].ws, vecs[v].lat, vecs[v].drop, vecs[v].stuck);
            reset_pulse(s);
            wait_done(s, !vecs[v].stuck, n);
            chk("vec_done_edge", n, vecs[v].edges);
            chk("vec_busy", {31'd0, busy[s]}, 32'd0);
            chk("vec_pass", {31'd0, pass[s]}, {31'd0, vecs[v].pass});
            chk("vec_id_ok", {31'd0, id_ok[s]}, {31'd0, vecs[v].id_ok});
            chk("vec_ts_ok", {31'd0, ts_ok[s]}, {31'd0, vecs[v].ts_ok});
            chk("vec_timeout_err", {31'd0, terr[s]}, {31'd0, vecs[v].terr});
            chk("vec_retry_count", {28'd0, retry[s]}, {28'd0, vecs[v].retry});
            chk("vec_id_value", id_value[s], vecs[v].idv);
            chk("vec_ts_value", ts_value[s], vecs[v].tsv);
            chk("vec_read_low", {31'd0, avm_read[s]}, 32'd0);
        end

        // start while busy ignored, start on DONE-entry edge ignored, restart from DONE
        set_cfg(0, 32'd0, TS_GOOD, 0, 1, 0, 1'b0);
        reset_pulse(0);
        edge_s(); edge_s();
        start[0] = 1'b1;
        edge_s();                         // edge 3, sequence busy
        start[0] = 1'b0;
        chk("start_busy_busy", {31'd0, busy[0]}, 32'd1);
        edge_s(); edge_s();
        start[0] = 1'b1;
        edge_s();                         // edge 6, EVAL -> DONE
        start[0] = 1'b0;
        chk("done_edge6", {31'd0, done[0]}, 32'd1);
        chk("pass_edge6", {31'd0, pass[0]}, 32'd1);
        edge_s();                         // edge 7
        chk("start_on_done_entry", {31'd0, done[0]}, 32'd1);
        chk("start_on_done_entry_busy", {31'd0, busy[0]}, 32'd0);
        start[0] = 1'b1;
        edge_s();                         // edge 8, restart
        start[0] = 1'b0;
        chk("restart_done_low", {31'd0, done[0]}, 32'd0);
        chk("restart_busy", {31'd0, busy[0]}, 32'd1);
        chk("restart_pass_clr", {31'd0, pass[0]}, 32'd0);
        chk("restart_id_hold", id_value[0], 32'd0);
        chk("restart_ts_hold", ts_value[0], TS_GOOD);
        wait_done(0, 1'b0, n);
        chk("restart_latency", n, 5);
        chk("restart_pass", {31'd0, pass[0]}, 32'd1);
        chk("restart_ts_ok", {31'd0, ts_ok[0]}, 32'd1);

        // Asynchronous reset during TS_WAIT
        set_cfg(0, 32'h0000_0000, TS_GOOD, 0, 1, 0, 1'b0);
        reset_pulse(0);
        edge_s(); edge_s(); edge_s(); edge_s();   // edge 4 accepts the timestamp read
        chk("pre_reset_busy", {31'd0, busy[0]}, 32'd1);
        rst_n[0] = 1'b0;
        #1;
        chk("async_reset_busy", {31'd0, busy[0]}, 32'd0);
        chk("async_reset_read", {31'd0, avm_read[0]}, 32'd0);
        chk("async_reset_ts", ts_value[0], 32'd0);
        @(negedge clock);
        @(negedge clock);
        rst_n[0] = 1'b1;
        wait_done(0, 1'b0, n);
        chk("rerun_done_edge", n, 6);
        chk("rerun_pass", {31'd0, pass[0]}, 32'd1);
        chk("rerun_ts_value", ts_value[0], TS_GOOD);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
